vector_tile_buffer: RTL and testbench



---
 rtl/vector_tile_buffer.sv | 150 +++++++++++++++
 tb/tb_vector_tile_buffer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_tile_buffer.sv
// vector_tile_buffer
// Responder side of the tile-streaming vector buffer interface used by the
// execution units. Holds NUM_BUFFERS buffers of TILES_PER_BUF tiles each.
// Every buffer has its own read and write tile pointer. Each pointer
// auto-increments, so initiators stream tiles without sending addresses.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   vec_read_enable      single-cycle read request pulse
//   vec_read_buffer_id   buffer to read
//   vec_read_tile        registered tile read data (1-cycle latency)
//   vec_read_valid       one-cycle pulse, read data valid
//   vec_write_enable     single-cycle write request pulse
//   vec_write_buffer_id  buffer to write
//   vec_write_tile       tile write data
//   rewind_enable        reset both pointers of one buffer to tile 0
//   rewind_buffer_id     buffer to rewind
//   bad_id_error         sticky flag, set when an out-of-range buffer id is used
module vector_tile_buffer #(
  parameter int DATA_WIDTH  = 8,
  parameter int TILE_ELEMS  = 32,
  parameter int MAX_ROWS    = 784,
  parameter int NUM_BUFFERS = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  vec_read_enable,
  input  logic [4:0]                            vec_read_buffer_id,
  output logic [TILE_ELEMS-1:0][DATA_WIDTH-1:0] vec_read_tile,
  output logic                                  vec_read_valid,
  input  logic                                  vec_write_enable,
  input  logic [4:0]                            vec_write_buffer_id,
  input  logic [TILE_ELEMS-1:0][DATA_WIDTH-1:0] vec_write_tile,
  input  logic                                  rewind_enable,
  input  logic [4:0]                            rewind_buffer_id,
  output logic                                  bad_id_error
);

  localparam int TILES_PER_BUF = (MAX_ROWS + TILE_ELEMS - 1) / TILE_ELEMS;
  localparam int PTR_W  = (TILES_PER_BUF > 1) ? $clog2(TILES_PER_BUF) : 1;
  localparam int BUF_W  = (NUM_BUFFERS > 1) ? $clog2(NUM_BUFFERS) : 1;
  localparam int DEPTH  = NUM_BUFFERS * TILES_PER_BUF;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [TILE_ELEMS-1:0][DATA_WIDTH-1:0] tile_t;

  // Storage is flat: buffer b, tile t lives at b*TILES_PER_BUF + t.
  // It is not cleared by reset.
  tile_t            r_mem [DEPTH];
  logic [PTR_W-1:0] r_rdPtr [NUM_BUFFERS];
  logic [PTR_W-1:0] r_wrPtr [NUM_BUFFERS];
  logic [PTR_W-1:0] w_rdPtrNext [NUM_BUFFERS];
  logic [PTR_W-1:0] w_wrPtrNext [NUM_BUFFERS];

  logic              w_rdIdOk, w_wrIdOk, w_rwIdOk;
  logic              w_rdGo, w_wrGo, w_rwGo;
  logic [BUF_W-1:0]  w_rdBuf, w_wrBuf;
  logic              w_rdRewound, w_wrRewound;
  logic [PTR_W-1:0]  w_rdTilePtr, w_wrTilePtr;
  logic [ADDR_W-1:0] w_rdAddr, w_wrAddr;

  function automatic logic [PTR_W-1:0] incPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(TILES_PER_BUF - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_rdIdOk = int'(vec_read_buffer_id)  < NUM_BUFFERS;
  assign w_wrIdOk = int'(vec_write_buffer_id) < NUM_BUFFERS;
  assign w_rwIdOk = int'(rewind_buffer_id)    < NUM_BUFFERS;

  assign w_rdGo = vec_read_enable  && w_rdIdOk;
  assign w_wrGo = vec_write_enable && w_wrIdOk;
  assign w_rwGo = rewind_enable    && w_rwIdOk;

  assign w_rdBuf = vec_read_buffer_id[BUF_W-1:0];
  assign w_wrBuf = vec_write_buffer_id[BUF_W-1:0];

  // A rewind of the same buffer in the same cycle takes effect before the
  // access, so that access uses tile 0.
  assign w_rdRewound = w_rwGo && (rewind_buffer_id == vec_read_buffer_id);
  assign w_wrRewound = w_rwGo && (rewind_buffer_id == vec_write_buffer_id);

  assign w_rdTilePtr = w_rdRewound ? '0 : r_rdPtr[w_rdBuf];
  assign w_wrTilePtr = w_wrRewound ? '0 : r_wrPtr[w_wrBuf];

  assign w_rdAddr = ADDR_W'(int'(w_rdBuf) * TILES_PER_BUF + int'(w_rdTilePtr));
  assign w_wrAddr = ADDR_W'(int'(w_wrBuf) * TILES_PER_BUF + int'(w_wrTilePtr));

  // Next pointer values. The rewind is applied first. Then an access to the
  // buffer advances its pointer from the rewound value. Out-of-range ids
  // never change a pointer.
  always_comb begin
    for (int b = 0; b < NUM_BUFFERS; b++) begin
      w_rdPtrNext[b] = r_rdPtr[b];
      w_wrPtrNext[b] = r_wrPtr[b];
      if (w_rwGo && int'(rewind_buffer_id) == b) begin
        w_rdPtrNext[b] = '0;
        w_wrPtrNext[b] = '0;
      end
      if (w_rdGo && int'(vec_read_buffer_id) == b) begin
        w_rdPtrNext[b] = incPtr(w_rdTilePtr);
      end
      if (w_wrGo && int'(vec_write_buffer_id) == b) begin
        w_wrPtrNext[b] = incPtr(w_wrTilePtr);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NUM_BUFFERS; b++) begin
        r_rdPtr[b] <= '0;
        r_wrPtr[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BUFFERS; b++) begin
        r_rdPtr[b] <= w_rdPtrNext[b];
        r_wrPtr[b] <= w_wrPtrNext[b];
      end
    end
  end

  // Tile storage. A read of the same tile in the same cycle gets the old
  // contents, because the read samples before this update lands.
  always_ff @(posedge clk) begin
    if (w_wrGo) begin
      r_mem[w_wrAddr] <= vec_write_tile;
    end
  end

  // Read response. A bad id still produces a valid pulse with a zero tile,
  // so the initiator never waits forever. The tile holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_read_valid <= 1'b0;
      vec_read_tile  <= '0;
      bad_id_error   <= 1'b0;
    end else begin
      vec_read_valid <= vec_read_enable;
      if (vec_read_enable) begin
        vec_read_tile <= w_rdIdOk ? r_mem[w_rdAddr] : '0;
      end
      if ((vec_read_enable && !w_rdIdOk) ||
          (vec_write_enable && !w_wrIdOk) ||
          (rewind_enable && !w_rwIdOk)) begin
        bad_id_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vector_tile_buffer.sv
// tb_vector_tile_buffer
// Directed, table-driven bench for vector_tile_buffer. It covers:
//   - a per-cycle vector table
//   - sequences for streaming, sign preservation, pointer wrap,
//     bad ids and mid-stream reset
module tb_vector_tile_buffer;

  typedef logic [31:0][7:0] tile_t;

  typedef struct {
    logic       rwEn;
    logic [4:0] rwId;
    logic       rdEn;
    logic [4:0] rdId;
    logic       wrEn;
    logic [4:0] wrId;
    logic [7:0] wrFill;
    logic       expValid;
    logic [7:0] expFill;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       vec_read_enable;
  logic [4:0] vec_read_buffer_id;
  tile_t      vec_read_tile;
  logic       vec_read_valid;
  logic       vec_write_enable;
  logic [4:0] vec_write_buffer_id;
  tile_t      vec_write_tile;
  logic       rewind_enable;
  logic [4:0] rewind_buffer_id;
  logic       bad_id_error;

  int compared   = 0;
  int mismatched = 0;
  int validCount;
  vec_t table_v [11];

  vector_tile_buffer dut (
    .clk                 (clk),
    .rst                 (rst),
    .vec_read_enable     (vec_read_enable),
    .vec_read_buffer_id  (vec_read_buffer_id),
    .vec_read_tile       (vec_read_tile),
    .vec_read_valid      (vec_read_valid),
    .vec_write_enable    (vec_write_enable),
    .vec_write_buffer_id (vec_write_buffer_id),
    .vec_write_tile      (vec_write_tile),
    .rewind_enable       (rewind_enable),
    .rewind_buffer_id    (rewind_buffer_id),
    .bad_id_error        (bad_id_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic tile_t fillTile(input logic [7:0] v);
    tile_t t;
    for (int i = 0; i < 32; i++) t[i] = v;
    return t;
  endfunction

  function automatic tile_t patternTile(input int tt);
    tile_t t;
    for (int i = 0; i < 32; i++) t[i] = 8'(tt + i);
    return t;
  endfunction

  // Drive one cycle of requests. Outputs are sampled 1 time unit after the edge.
  task automatic applyStimulus(input logic rwEn, input logic [4:0] rwId,
                               input logic rdEn, input logic [4:0] rdId,
                               input logic wrEn, input logic [4:0] wrId,
                               input tile_t wrTile);
    rewind_enable       = rwEn;
    rewind_buffer_id    = rwId;
    vec_read_enable     = rdEn;
    vec_read_buffer_id  = rdId;
    vec_write_enable    = wrEn;
    vec_write_buffer_id = wrId;
    vec_write_tile      = wrTile;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, '0);
  endtask

  task automatic checkOutput(input string name, input logic expValid,
                             input logic chkTile, input tile_t expTile);
    compared++;
    if (vec_read_valid !== expValid) begin
      mismatched++;
      $display("[TB] FAIL %s valid: got %0b, expected %0b", name, vec_read_valid, expValid);
    end
    if (chkTile) begin
      compared++;
      if (vec_read_tile !== expTile) begin
        mismatched++;
        $display("[TB] FAIL %s tile: got %h, expected %h", name, vec_read_tile, expTile);
      end
    end
  endtask

  task automatic checkBad(input string name, input logic exp);
    compared++;
    if (bad_id_error !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s bad_id_error: got %0b, expected %0b", name, bad_id_error, exp);
    end
  endtask

  initial begin
    tile_t lastTile;
    tile_t signTile;

    rst = 1'b1;
    rewind_enable = 1'b0; rewind_buffer_id = '0;
    vec_read_enable = 1'b0; vec_read_buffer_id = '0;
    vec_write_enable = 1'b0; vec_write_buffer_id = '0;
    vec_write_tile = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 1'b0, 1'b1, '0);
    checkBad("reset", 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Per-cycle table. The expectation in each row is the response to that
    // row's read. Rows with expValid=0 check that the previous tile is held.
    table_v[0]  = '{1, 5'd1, 0, 5'd0, 0, 5'd0, 8'h00, 0, 8'h00};
    table_v[1]  = '{0, 5'd0, 0, 5'd0, 1, 5'd1, 8'h03, 0, 8'h00};
    table_v[2]  = '{1, 5'd1, 1, 5'd1, 1, 5'd1, 8'h07, 1, 8'h03};
    table_v[3]  = '{0, 5'd0, 0, 5'd0, 0, 5'd0, 8'h00, 0, 8'h03};
    table_v[4]  = '{1, 5'd1, 1, 5'd1, 0, 5'd0, 8'h00, 1, 8'h07};
    table_v[5]  = '{0, 5'd0, 0, 5'd0, 1, 5'd4, 8'h11, 0, 8'h07};
    table_v[6]  = '{0, 5'd0, 1, 5'd4, 1, 5'd5, 8'h22, 1, 8'h11};
    table_v[7]  = '{0, 5'd0, 1, 5'd5, 0, 5'd0, 8'h00, 1, 8'h22};
    table_v[8]  = '{0, 5'd0, 0, 5'd0, 1, 5'd5, 8'h33, 0, 8'h22};
    table_v[9]  = '{0, 5'd0, 1, 5'd5, 1, 5'd5, 8'h44, 1, 8'h33};
    table_v[10] = '{0, 5'd0, 1, 5'd5, 0, 5'd0, 8'h00, 1, 8'h44};
    for (int k = 0; k < 11; k++) begin
      applyStimulus(table_v[k].rwEn, table_v[k].rwId, table_v[k].rdEn, table_v[k].rdId,
                    table_v[k].wrEn, table_v[k].wrId, fillTile(table_v[k].wrFill));
      checkOutput($sformatf("table[%0d]", k), table_v[k].expValid,
                  (k >= 2), fillTile(table_v[k].expFill));
    end
    checkBad("table", 1'b0);

    // Stream a full buffer out with back-to-back reads.
    applyStimulus(1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0, '0);
    for (int t = 0; t < 25; t++)
      applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd2, patternTile(t));
    applyStimulus(1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0, '0);
    validCount = 0;
    for (int t = 0; t < 25; t++) begin
      applyStimulus(1'b0, 5'd0, 1'b1, 5'd2, 1'b0, 5'd0, '0);
      if (vec_read_valid === 1'b1) validCount++;
      checkOutput($sformatf("stream[%0d]", t), 1'b1, 1'b1, patternTile(t));
    end
    idle();
    checkOutput("stream end", 1'b0, 1'b1, patternTile(24));
    compared++;
    if (validCount != 25) begin
      mismatched++;
      $display("[TB] FAIL stream pulses: got %0d, expected 25", validCount);
    end

    // Sign-extreme elements pass through unchanged.
    for (int i = 0; i < 32; i++) signTile[i] = (i % 2 == 0) ? 8'hFF : 8'h80;
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, signTile);
    applyStimulus(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, '0);
    checkOutput("sign", 1'b1, 1'b1, signTile);
    compared++;
    if ($signed(vec_read_tile[0]) != -8'sd1 || $signed(vec_read_tile[1]) != -8'sd128) begin
      mismatched++;
      $display("[TB] FAIL sign elems: got %0d/%0d, expected -1/-128",
               $signed(vec_read_tile[0]), $signed(vec_read_tile[1]));
    end

    // The 26th write wraps around to tile 0.
    applyStimulus(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, '0);
    for (int t = 0; t < 26; t++)
      applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3,
                    fillTile((t == 25) ? 8'h09 : 8'(8'h20 + t)));
    applyStimulus(1'b1, 5'd3, 1'b1, 5'd3, 1'b0, 5'd0, '0);
    checkOutput("wrap tile0", 1'b1, 1'b1, fillTile(8'h09));
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 5'd0, '0);
    checkOutput("wrap tile1", 1'b1, 1'b1, fillTile(8'h21));

    // Out-of-range ids: the read is answered with zeros, the write is
    // dropped and the rewind is ignored.
    for (int b = 0; b < 8; b++)
      applyStimulus(1'b1, 5'(b), 1'b0, 5'd0, 1'b1, 5'(b), fillTile(8'(8'h40 + b)));
    checkBad("before bad", 1'b0);
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd12, 1'b0, 5'd0, '0);
    checkOutput("bad read", 1'b1, 1'b1, '0);
    checkBad("bad read", 1'b1);
    idle();
    checkOutput("bad idle", 1'b0, 1'b0, '0);
    checkBad("bad sticky", 1'b1);
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd12, fillTile(8'h5A));
    applyStimulus(1'b1, 5'd12, 1'b0, 5'd0, 1'b0, 5'd0, '0);
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4, fillTile(8'h66));
    checkBad("bad after write", 1'b1);
    for (int b = 0; b < 8; b++) begin
      applyStimulus(1'b1, 5'(b), 1'b1, 5'(b), 1'b0, 5'd0, '0);
      checkOutput($sformatf("bad keep buf%0d", b), 1'b1, 1'b1, fillTile(8'(8'h40 + b)));
    end
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd4, 1'b0, 5'd0, '0);
    checkOutput("bad buf4 tile1", 1'b1, 1'b1, fillTile(8'h66));

    // Reset during a pending valid cancels it at once and clears pointers.
    applyStimulus(1'b1, 5'd6, 1'b0, 5'd0, 1'b1, 5'd6, fillTile(8'h61));
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd6, fillTile(8'h62));
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd6, 1'b0, 5'd0, '0);
    checkOutput("pre-rst tile0", 1'b1, 1'b1, fillTile(8'h61));
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd6, 1'b0, 5'd0, '0);
    checkOutput("pre-rst tile1", 1'b1, 1'b1, fillTile(8'h62));
    vec_read_enable = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid rst", 1'b0, 1'b1, '0);
    checkBad("mid rst", 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd6, 1'b0, 5'd0, '0);
    checkOutput("post-rst read", 1'b1, 1'b1, fillTile(8'h61));
    lastTile = vec_read_tile;
    idle();
    checkOutput("post-rst hold", 1'b0, 1'b1, lastTile);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
